dispatch_gather_seq: RTL and testbench
======================================

DISPATCH_GATHER_SEQ -- requirements
Module: dispatch_gather_seq

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 47, bits per micro-op entry.
REQ-002 SHALL have parameter PUSH_WIDTH, default 4, maximum entries offered per cycle.
REQ-003 SHALL have parameter DEPTH, default 8, staging entries; power of two, >= PUSH_WIDTH.
REQ-004 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port flush, input, 1, synchronous discard of all staged entries.
REQ-007 SHALL have port in_data, input, DATA_WIDTH, single decoded micro-op.
REQ-008 SHALL have port in_valid, input, 1, in_data valid.
REQ-009 SHALL have port in_ready, output, 1, staging can accept one entry.
REQ-010 SHALL have port out_data, output, DATA_WIDTH*PUSH_WIDTH, group offered downstream; slot i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-011 SHALL have port out_valid_ct, output, $clog2(PUSH_WIDTH)+1, number of valid leading slots.
REQ-012 SHALL have port out_ready_ct, input, $clog2(PUSH_WIDTH)+1, number of leading slots downstream can take this cycle.
REQ-013 SHALL have port occupancy, output, $clog2(DEPTH)+1, staged entry count.

Function
REQ-014 SHALL store accepted entries in a ring (head, tail, count) and preserve arrival order end to end.
REQ-015 SHALL accept in_data on a cycle where in_valid && in_ready && !flush.
REQ-016 SHALL drive in_ready = (count < DEPTH) && !flush; in_ready SHALL NOT depend on out_ready_ct (no combinational path).
REQ-017 SHALL drive out_valid_ct = min(count, PUSH_WIDTH), forced 0 while flush is high.
REQ-018 SHALL place entry head+i (mod DEPTH) in slot i for i < out_valid_ct; slots >= out_valid_ct SHALL be driven zero.
REQ-019 SHALL transfer n = min(out_valid_ct, out_ready_ct) entries per cycle; values of out_ready_ct above out_valid_ct SHALL be treated as out_valid_ct.
REQ-020 SHALL advance head by n mod DEPTH and tail by 1 mod DEPTH per accepted push; both pointers wrap.
REQ-021 SHALL update count = count + push - n on simultaneous push and pop; a full ring with n >= 1 still deasserts in_ready that cycle (push refused, pop proceeds).
REQ-022 SHALL make an entry accepted in cycle t visible in out_data no earlier than cycle t+1 (no bypass).
REQ-023 SHALL give flush priority over push and pop: head, tail, count cleared next edge; no transfer is counted in the flush cycle.
REQ-024 SHALL drive occupancy = count (registered).
REQ-025 SHALL keep out_data/out_valid_ct stable while out_ready_ct = 0 and no flush.

Reset
REQ-026 SHALL, on rst low, asynchronously clear head, tail, count; storage contents need not reset.
REQ-027 SHALL drive during and after reset: in_ready 1, out_valid_ct 0, out_data 0, occupancy 0.
REQ-028 SHALL discard any partially transferred group when rst asserts mid-operation; no entry reappears after release.

Structure
REQ-029 SHALL take default DATA_WIDTH and PUSH_WIDTH from the shared dispatch parameter package also used by the issue buffer; DEPTH stays local.
REQ-030 SHALL implement storage as one sub-module multi_read_ring (one write port, PUSH_WIDTH read ports indexed from head); pointer/count logic stays in dispatch_gather_seq.

Verification
REQ-031 SHALL test reset: push 3 entries, assert rst low mid-cycle -> out_valid_ct 0, occupancy 0, in_ready 1 immediately; after release out_valid_ct stays 0.
REQ-032 SHALL test gather: push A,B,C,D,E with out_ready_ct 0 -> out_valid_ct 4, slots A..D, occupancy 5; then out_ready_ct 4 -> next cycle out_valid_ct 1, slot0 E.
REQ-033 SHALL test partial take: 4 staged, out_ready_ct 2 -> next cycle slots 0,1 hold the 3rd and 4th entries, occupancy 2; out_ready_ct 7 with 2 valid -> exactly 2 taken.
REQ-034 SHALL test full/wrap: fill 8 entries -> in_ready 0; pop 3 while in_valid high -> no push that cycle, in_ready 1 next; continue 20 pushes/pops, scoreboard order matches.
REQ-035 SHALL test flush: 6 staged, flush with in_valid high and out_ready_ct 4 -> out_valid_ct 0 and in_ready 0 that cycle, occupancy 0 next, pushed entry dropped.

Source files
------------

// File: rtl/dispatch_gather_seq_pkg.sv
// Shared dispatch parameters: micro-op width and dispatch group width,
// common to the gather stage and the issue buffer.
package dispatch_gather_seq_pkg;

  localparam int DISPATCH_DATA_WIDTH = 47;
  localparam int DISPATCH_PUSH_WIDTH = 4;

  function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/dispatch_gather_seq_multi_read_ring.sv
// Ring storage: one write port, PUSH_WIDTH read ports at head, head+1, ...
// Read ports wrap modulo DEPTH, which must be a power of two.
module multi_read_ring #(
  parameter int DATA_WIDTH = 47,
  parameter int PUSH_WIDTH = 4,
  parameter int DEPTH      = 8
) (
  input  logic                             clk,
  input  logic                             i_we,
  input  logic [$clog2(DEPTH)-1:0]         i_waddr,
  input  logic [DATA_WIDTH-1:0]            i_wdata,
  input  logic [$clog2(DEPTH)-1:0]         i_head,
  output logic [DATA_WIDTH*PUSH_WIDTH-1:0] o_rd_data
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // NOTE: storage has no reset; validity is tracked by the pointers, and a reset-free array maps onto RAM.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  for (genvar i = 0; i < PUSH_WIDTH; i++) begin : g_rd
    assign o_rd_data[i*DATA_WIDTH +: DATA_WIDTH] = r_mem[i_head + PTR_W'(i)];
  end

endmodule

// File: rtl/dispatch_gather_seq.sv
// Dispatch gather stage: stages single micro-ops in a ring and offers up to
// PUSH_WIDTH of them per cycle downstream, in arrival order.
module dispatch_gather_seq
  import dispatch_gather_seq_pkg::*;
#(
  parameter int DATA_WIDTH = DISPATCH_DATA_WIDTH,
  parameter int PUSH_WIDTH = DISPATCH_PUSH_WIDTH,
  parameter int DEPTH      = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic [DATA_WIDTH-1:0]            in_data,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic [DATA_WIDTH*PUSH_WIDTH-1:0] out_data,
  output logic [$clog2(PUSH_WIDTH):0]      out_valid_ct,
  input  logic [$clog2(PUSH_WIDTH):0]      out_ready_ct,
  output logic [$clog2(DEPTH):0]           occupancy
);

  localparam int CT_W  = $clog2(PUSH_WIDTH) + 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]                 r_head;
  logic [PTR_W-1:0]                 r_tail;
  logic [CNT_W-1:0]                 r_count;
  logic                             w_push;
  logic [CT_W-1:0]                  w_valid_ct;
  logic [CT_W-1:0]                  w_take;
  logic [DATA_WIDTH*PUSH_WIDTH-1:0] w_rd_data;

  // in_ready looks only at registered count and flush, never at out_ready_ct.
  assign in_ready   = (r_count < CNT_W'(DEPTH)) && !flush;
  assign w_push     = in_valid && in_ready;
  assign w_valid_ct = flush ? '0 : CT_W'(min_u(32'(r_count), PUSH_WIDTH));
  assign w_take     = (out_ready_ct < w_valid_ct) ? out_ready_ct : w_valid_ct;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + PTR_W'(1);
      r_head  <= r_head + PTR_W'(w_take);
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_take);
    end
  end

  multi_read_ring #(
    .DATA_WIDTH (DATA_WIDTH),
    .PUSH_WIDTH (PUSH_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ring (
    .clk       (clk),
    .i_we      (w_push),
    .i_waddr   (r_tail),
    .i_wdata   (in_data),
    .i_head    (r_head),
    .o_rd_data (w_rd_data)
  );

  // NOTE: out_data gets a default before the loop so no latch is inferred for masked slots.
  always_comb begin
    out_data = '0;
    for (int i = 0; i < PUSH_WIDTH; i++) begin
      if (CT_W'(i) < w_valid_ct) out_data[i*DATA_WIDTH +: DATA_WIDTH] = w_rd_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign out_valid_ct = w_valid_ct;
  assign occupancy    = r_count;

endmodule

// File: tb/tb_dispatch_gather_seq.sv
// Scoreboard bench for dispatch_gather_seq: accepted entries queue up as expected
// data; a negedge monitor checks offered slots and retires transferred entries.
module tb_dispatch_gather_seq;

  localparam int DW = 47;
  localparam int PW = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            flush = 1'b0;
  logic [DW-1:0]   in_data = '0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [DW*PW-1:0] out_data;
  logic [2:0]      out_valid_ct;
  logic [2:0]      out_ready_ct = '0;
  logic [3:0]      occupancy;

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] exp_q [$];

  dispatch_gather_seq dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out_data     (out_data),
    .out_valid_ct (out_valid_ct),
    .out_ready_ct (out_ready_ct),
    .occupancy    (occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] slot(input int i);
    return out_data[i*DW +: DW];
  endfunction

  // Drive one cycle's inputs just after the rising edge.
  task automatic drive(input logic v, input logic [DW-1:0] d, input logic [2:0] rdy, input logic fl);
    @(posedge clk);
    #1;
    in_valid     = v;
    in_data      = d;
    out_ready_ct = rdy;
    flush        = fl;
  endtask

  // After the monitor has run for this cycle, record what the DUT will accept at the next edge.
  task automatic tick();
    @(negedge clk);
    #2;
    if (flush) exp_q.delete();
    else if (in_valid && in_ready) exp_q.push_back(in_data);
  endtask

  always @(negedge clk) begin
    int vc;
    int n;
    int ev;
    if (rst) begin
      vc = int'(out_valid_ct);
      n  = (int'(out_ready_ct) < vc) ? int'(out_ready_ct) : vc;
      ev = flush ? 0 : ((exp_q.size() < PW) ? exp_q.size() : PW);
      check("mon_occupancy", 64'(occupancy), 64'(exp_q.size()));
      check("mon_valid_ct", 64'(out_valid_ct), 64'(ev));
      for (int i = 0; i < PW; i++) begin
        if (i < vc) begin
          if (i >= exp_q.size()) begin
            total++;
            bad++;
            $display("FAIL mon_extra_slot: slot %0d valid with only %0d expected entries", i, exp_q.size());
          end else begin
            check("mon_slot_data", 64'(slot(i)), 64'(exp_q[i]));
          end
        end else begin
          check("mon_slot_zero", 64'(slot(i)), 64'd0);
        end
      end
      for (int i = 0; i < n; i++) if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #3;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_valid_ct", 64'(out_valid_ct), 64'd0);
    check("rst_occupancy", 64'(occupancy), 64'd0);
    check("rst_out_data", 64'(out_data[63:0]), 64'd0);
    @(posedge clk);
    #3 rst = 1'b1;

    // Reset mid-operation drops staged entries
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, DW'(64'h71 + i), 3'd0, 1'b0);
      tick();
    end
    drive(1'b0, '0, 3'd0, 1'b0);
    tick();
    check("pre_rst_occupancy", 64'(occupancy), 64'd3);
    rst = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_valid_ct", 64'(out_valid_ct), 64'd0);
    check("mid_rst_occupancy", 64'(occupancy), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #3 rst = 1'b1;
    drive(1'b0, '0, 3'd0, 1'b0);
    tick();
    check("post_rst_valid_ct", 64'(out_valid_ct), 64'd0);
    check("post_rst_occupancy", 64'(occupancy), 64'd0);

    // Gather A..E with downstream stalled
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, DW'(64'hA1 + 64'h11 * i), 3'd0, 1'b0);
      tick();
    end
    drive(1'b0, '0, 3'd0, 1'b0);
    tick();
    check("gather_valid_ct", 64'(out_valid_ct), 64'd4);
    check("gather_slot0", 64'(slot(0)), 64'hA1);
    check("gather_slot3", 64'(slot(3)), 64'hD4);
    check("gather_occupancy", 64'(occupancy), 64'd5);
    drive(1'b0, '0, 3'd4, 1'b0);
    tick();
    drive(1'b0, '0, 3'd0, 1'b0);
    tick();
    check("gather_rest_valid_ct", 64'(out_valid_ct), 64'd1);
    check("gather_rest_slot0", 64'(slot(0)), 64'hE5);
    check("gather_rest_slot1", 64'(slot(1)), 64'd0);
    drive(1'b0, '0, 3'd4, 1'b0);
    tick();

    // Partial take, then oversized ready count
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, DW'(64'h51 + i), 3'd0, 1'b0);
      tick();
    end
    drive(1'b0, '0, 3'd2, 1'b0);
    tick();
    drive(1'b0, '0, 3'd0, 1'b0);
    tick();
    check("partial_slot0", 64'(slot(0)), 64'h53);
    check("partial_slot1", 64'(slot(1)), 64'h54);
    check("partial_occupancy", 64'(occupancy), 64'd2);
    drive(1'b0, '0, 3'd7, 1'b0);
    tick();
    drive(1'b0, '0, 3'd0, 1'b0);
    tick();
    check("over_ready_occupancy", 64'(occupancy), 64'd0);
    check("over_ready_valid_ct", 64'(out_valid_ct), 64'd0);

    // Fill, full refusal during pop, then wrapping traffic
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, DW'(64'h100 + i), 3'd0, 1'b0);
      tick();
    end
    drive(1'b0, '0, 3'd0, 1'b0);
    tick();
    check("full_in_ready", 64'(in_ready), 64'd0);
    check("full_occupancy", 64'(occupancy), 64'd8);
    drive(1'b1, DW'(64'h1FF), 3'd3, 1'b0);
    tick();
    check("full_pop_in_ready", 64'(in_ready), 64'd0);
    drive(1'b0, '0, 3'd0, 1'b0);
    tick();
    check("after_pop_in_ready", 64'(in_ready), 64'd1);
    check("after_pop_occupancy", 64'(occupancy), 64'd5);
    check("after_pop_slot0", 64'(slot(0)), 64'h103);
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, DW'(64'h200 + i), 3'(i % 5), 1'b0);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, '0, 3'd4, 1'b0);
      tick();
    end
    drive(1'b0, '0, 3'd0, 1'b0);
    tick();
    check("wrap_drained", 64'(occupancy), 64'd0);

    // Flush beats push and pop
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, DW'(64'h300 + i), 3'd0, 1'b0);
      tick();
    end
    drive(1'b1, DW'(64'h3FF), 3'd4, 1'b1);
    tick();
    check("flush_valid_ct", 64'(out_valid_ct), 64'd0);
    check("flush_in_ready", 64'(in_ready), 64'd0);
    check("flush_out_data", 64'(out_data[63:0]), 64'd0);
    drive(1'b0, '0, 3'd0, 1'b0);
    tick();
    check("post_flush_occupancy", 64'(occupancy), 64'd0);
    drive(1'b1, DW'(64'h3AA), 3'd0, 1'b0);
    tick();
    drive(1'b0, '0, 3'd0, 1'b0);
    tick();
    check("post_flush_slot0", 64'(slot(0)), 64'h3AA);
    check("post_flush_count", 64'(occupancy), 64'd1);
    drive(1'b0, '0, 3'd4, 1'b0);
    tick();
    drive(1'b0, '0, 3'd0, 1'b0);
    tick();
    check("final_empty", 64'(occupancy), 64'd0);
    check("final_queue", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
